// File: rtl/trng_ctrl_pkg.sv
// rtl/trng_ctrl_pkg.sv - shared types and defaults for the TRNG word controller
//
// Contents:
//   state_t        controller state encoding (3 bits)
//   *_DEF          default values for WORD_W, WARMUP and REP_LIMIT
//   max_int()      elaboration-time helper used to size the bit counter
package trng_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam int WORD_W_DEF    = 32;
  localparam int WARMUP_DEF    = 64;
  localparam int REP_LIMIT_DEF = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trng_word_ctrl_if.sv
// rtl/trng_word_ctrl_if.sv - core/consumer signal bundle for the TRNG word controller
//
// Signals:
//   req          consumer wants words (level)
//   core_en      enable to the TRNG core
//   bit_valid    core out_valid
//   bit_in       core out
//   word         packed random word
//   word_valid   word available
//   word_ready   consumer accepts word
//   busy         controller is in WARMUP or COLLECT
//   fault        sticky health-test failure
//   clear_fault  single-cycle pulse to leave FAULT
// Modports:
//   master       the controller
//   slave        the environment (core + consumer)
interface trng_word_ctrl_if
  import trng_ctrl_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);

  logic              req;
  logic              core_en;
  logic              bit_valid;
  logic              bit_in;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_ready;
  logic              busy;
  logic              fault;
  logic              clear_fault;

  modport master (
    input  req,
    input  bit_valid,
    input  bit_in,
    input  word_ready,
    input  clear_fault,
    output core_en,
    output word,
    output word_valid,
    output busy,
    output fault
  );

  modport slave (
    output req,
    output bit_valid,
    output bit_in,
    output word_ready,
    output clear_fault,
    input  core_en,
    input  word,
    input  word_valid,
    input  busy,
    input  fault
  );

endinterface

// File: rtl/trng_rep_test.sv
// rtl/trng_rep_test.sv - repetition-count health test on the accepted bit stream
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   clr        clears the run counter and last-bit register
//   bit_valid  an accepted bit is present this cycle
//   bit_in     the accepted bit
//   fail       this bit brings the run length to REP_LIMIT (combinational)
module trng_rep_test
  import trng_ctrl_pkg::*;
#(
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic fail
);

  localparam int            RW      = $clog2(REP_LIMIT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(REP_LIMIT);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);

  logic [RW-1:0] run_q, run_d;
  logic          last_q, last_d;

  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (clr) begin
      run_d  = '0;
      last_d = 1'b0;
    end else if (bit_valid) begin
      last_d = bit_in;
      // run_q == 0 marks "no bit seen since clear", so last_q is not meaningful yet.
      if (run_q == '0 || bit_in != last_q) begin
        run_d = RUN_ONE;
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_ONE;
      end
    end
  end

  // Flag on the same cycle as the offending bit so the controller can let the
  // fault take priority over a word that this very bit would complete.
  assign fail = bit_valid && !clr && (run_d == RUN_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/trng_word_ctrl.sv
// rtl/trng_word_ctrl.sv - sequences the TRNG core, discards warm-up, packs words
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    trng_word_ctrl_if.master: req/core_en/bit_valid/bit_in from and to
//          the core, word/word_valid/word_ready to the consumer, busy/fault
//          status and clear_fault
// Parameters:
//   WORD_W     bits per output word (>= 2)
//   WARMUP     accepted bits discarded after each start from IDLE (>= 1)
//   REP_LIMIT  identical-bit run length that declares a fault (>= 2)
module trng_word_ctrl
  import trng_ctrl_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int WARMUP    = WARMUP_DEF,
  parameter int REP_LIMIT = REP_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  trng_word_ctrl_if.master bus
);

  localparam int            CW        = $clog2(max_int(WARMUP, WORD_W) + 1);
  localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(WORD_W - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_q, word_d;

  logic bit_acc;
  logic rep_clr;
  logic rep_fail;

  // Bits only count while the core is meant to be running.
  assign bit_acc = bus.bit_valid && (state_q == ST_WARMUP || state_q == ST_COLLECT);

  // The run restarts only from IDLE; a HOLD->COLLECT turnaround keeps it.
  assign rep_clr = (state_q == ST_IDLE);

  trng_rep_test #(
    .REP_LIMIT (REP_LIMIT)
  ) u_rep_test (
    .clk       (clk),
    .reset     (reset),
    .clr       (rep_clr),
    .bit_valid (bit_acc),
    .bit_in    (bus.bit_in),
    .fail      (rep_fail)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        shreg_d = '0;
        if (bus.req) begin
          state_d = ST_WARMUP;
        end
      end

      ST_WARMUP: begin
        if (bit_acc) begin
          if (rep_fail) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
          end else if (cnt_q == WARM_LAST) begin
            state_d = ST_COLLECT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_COLLECT: begin
        if (bit_acc) begin
          if (rep_fail) begin
            // Fault wins even on the completing bit: partial word dropped,
            // published word left untouched.
            state_d = ST_FAULT;
            cnt_d   = '0;
            shreg_d = '0;
          end else begin
            // First bit of the word ends up as the MSB.
            shreg_d = {shreg_q[WORD_W-2:0], bus.bit_in};
            if (cnt_q == WORD_LAST) begin
              word_d  = shreg_d;
              state_d = ST_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
      end

      ST_HOLD: begin
        if (bus.word_ready) begin
          state_d = bus.req ? ST_COLLECT : ST_IDLE;
        end
      end

      ST_FAULT: begin
        if (bus.clear_fault) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
    end
  end

  // Status decodes straight from the state register: reset forces them low
  // immediately and they cannot glitch on input activity.
  assign bus.core_en    = (state_q == ST_WARMUP) || (state_q == ST_COLLECT);
  assign bus.busy       = (state_q == ST_WARMUP) || (state_q == ST_COLLECT);
  assign bus.word_valid = (state_q == ST_HOLD);
  assign bus.fault      = (state_q == ST_FAULT);
  assign bus.word       = word_q;

endmodule

// File: doc/trng_word_ctrl.md
Name: trng_word_ctrl

Overview:
Controller that sequences the Markov TRNG core. It gates the core on and off, discards warm-up bits, and packs debiased bits (`out_valid`/`out` of the core) into words. It runs a repetition-count health test and presents each word to one consumer over a valid/ready handshake. It sits between the trng core and the consumer (bus register or seed FIFO).

Parameters:
- WORD_W, 32: bits per output word; minimum 2.
- WARMUP, 64: accepted bits discarded after each start from IDLE; minimum 1.
- REP_LIMIT, 16: run length of identical bits that declares a fault; minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  level; consumer wants words.
- core_en  out  1  enable to trng core.
- bit_valid  in  1  core out_valid.
- bit_in  in  1  core out.
- word  out  WORD_W  packed random word.
- word_valid  out  1  word available.
- word_ready  in  1  consumer accepts word.
- busy  out  1  high in WARMUP or COLLECT.
- fault  out  1  health test failed; sticky.
- clear_fault  in  1  single-cycle pulse; leave FAULT.

Behaviour:
- Reset (async, any state): state=IDLE. core_en=0, word=0, word_valid=0, busy=0, fault=0. All counters and the shift register are cleared.
- An accepted bit is bit_valid=1 in WARMUP or COLLECT. bit_valid is ignored in IDLE, HOLD and FAULT.
- IDLE:
  - core_en=0.
  - req=1 → WARMUP on the next edge; core_en=1 from that cycle.
  - The run counter is cleared.
- WARMUP:
  - Count accepted bits and discard them.
  - On the WARMUP-th accepted bit → COLLECT.
  - Warm-up bits do feed the health test.
  - req dropping has no effect; the word completes.
- COLLECT:
  - Each accepted bit is shifted in as shreg <= {shreg[WORD_W-2:0], bit_in}, so the first bit ends up as the MSB.
  - On the WORD_W-th accepted bit: word <= completed value, then → HOLD.
  - word_valid=1 and core_en=0 from the next cycle, giving 1-cycle latency from the final accepted bit.
- HOLD:
  - word_valid=1; word is stable until the handshake.
  - On word_valid & word_ready: word_valid=0 next cycle.
  - If req=1 in the handshake cycle → COLLECT with no warm-up; core_en=1 next cycle; run counter kept.
  - Otherwise → IDLE.
- Health test:
  - run=1 on the first accepted bit after IDLE.
  - After that, run+1 if bit_in equals the previous bit, else run=1.
  - run reaching REP_LIMIT → FAULT on the next edge. The partial word is discarded and word is unchanged.
- FAULT:
  - fault=1, core_en=0, word_valid=0.
  - clear_fault=1 → IDLE, fault=0 next cycle.
  - clear_fault in any other state is ignored.
- Simultaneous events:
  - Fault on the bit that completes a word: the fault wins, no HOLD, and word is not updated.
- Widths:
  - Bit counter is $clog2(max(WARMUP,WORD_W)+1) bits.
  - Run counter is $clog2(REP_LIMIT+1) bits and saturates at REP_LIMIT.
- Reset mid-operation: the partial word is lost and no word_valid glitch occurs.

Decomposition:
- Package trng_ctrl_pkg holds:
  - the state enum {IDLE, WARMUP, COLLECT, HOLD, FAULT}, 3-bit encoding;
  - default constants for WORD_W, WARMUP and REP_LIMIT.
- Sub-module trng_rep_test holds the run counter and last-bit register. Inputs: clk, reset, clr, bit_valid, bit_in. Output: fail.

Test Plan:
All scenarios use WORD_W=8 and WARMUP=4 unless stated.
1. Basic word: req=1, warm-up bits 1,0,1,1, then bits 1,0,1,0,0,1,1,0 → word=8'hA6 and word_valid=1 one cycle after the 8th bit. core_en=0 in that cycle. busy is high through warm-up and collect.
2. Gaps and backpressure: bit_valid asserted every 3rd cycle → same 8'hA6 result. Then hold word_ready=0 for 10 cycles while pulsing bit_valid=1 → word is stable at 8'hA6 and no bits are taken.
3. Back-to-back: keep req=1 and handshake → COLLECT with no warm-up. The next 8 bits 0x3C → word=8'h3C. With req=0 at the handshake → IDLE and core_en=0.
4. Health test, REP_LIMIT=4: in COLLECT feed 0,1,1,1,1 → fault=1 after the 4th consecutive 1. core_en=0, word_valid never asserts, word keeps its old value. clear_fault pulse → IDLE and fault=0. A stray clear_fault in IDLE has no effect.
5. Fault on final bit, REP_LIMIT=4: bits 1,0,1,0,1,1,1,1 (8th bit completes a run of 4) → FAULT, no word_valid, word unchanged.
6. Async reset: assert reset mid-COLLECT between clock edges → all outputs are 0 immediately. After release, a new req restarts with the full 4-bit warm-up.
